// File: rtl/delay_timer_pkg.sv
// Shared types and defaults for the delay/period timer bank.
// Config struct carries a full-width period; channels use only the low CBITS bits.
package delay_timer_pkg;

   localparam int CBITS_MAX     = 32;
   localparam int CBITS_DEF     = 16;
   localparam int DEFAULT_N_DEF = 50000;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } ch_state_t;

   typedef struct packed {
      logic [CBITS_MAX-1:0] period;
      logic                 periodic;
   } cfg_t;

endpackage

// File: rtl/delay_timer_bank_if.sv
// Config/control/status bundle for delay_timer_bank; slave = timer bank, master = controller.
interface delay_timer_bank_if #(
   parameter int NCH   = 4,
   parameter int CBITS = 16
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic             cfg_we;
   logic [CHW-1:0]   cfg_ch;
   logic [CBITS-1:0] cfg_period;
   logic             cfg_periodic;
   logic [NCH-1:0]   start;
   logic [NCH-1:0]   stop;
   logic [NCH-1:0]   err_clr;
   logic [NCH-1:0]   sig;
   logic [NCH-1:0]   flg;
   logic [NCH-1:0]   err;

   modport slave (
      input  cfg_we, cfg_ch, cfg_period, cfg_periodic, start, stop, err_clr,
      output sig, flg, err
   );

   modport master (
      output cfg_we, cfg_ch, cfg_period, cfg_periodic, start, stop, err_clr,
      input  sig, flg, err
   );
endinterface

// File: rtl/delay_timer_ch.sv
// One timer channel: pulses sig P cycles after start (one-shot or periodic), all outputs registered.
// Macro DELAY_TIMER_RETRIG_EN: start while running restarts the interval instead of flagging err.
module delay_timer_ch
   import delay_timer_pkg::*;
#(
   parameter int CBITS     = CBITS_DEF,
   parameter int DEFAULT_N = DEFAULT_N_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic we,
   input  cfg_t wr_cfg,
   input  logic start,
   input  logic stop,
   input  logic err_clr,
   output logic sig,
   output logic flg,
   output logic err
);

`ifdef DELAY_TIMER_RETRIG_EN
   localparam bit RETRIG = 1'b1;
`else
   localparam bit RETRIG = 1'b0;
`endif

   localparam cfg_t RST_CFG = '{period: CBITS_MAX'(DEFAULT_N), periodic: 1'b0};

   ch_state_t        state_q, state_d;
   logic [CBITS-1:0] cnt_q, cnt_d;
   cfg_t             cfg_q, cfg_d;
   cfg_t             pend_cfg_q, pend_cfg_d;
   logic             pend_q, pend_d;
   logic             sig_q, sig_d;
   logic             flg_q, flg_d;
   logic             err_q, err_d;

   logic [CBITS-1:0] period;
   logic             wr_ok;
   logic             wr_bad;
   logic             eff_pend;
   cfg_t             eff_cfg;
   logic             tc;
   logic             err_set;

   assign period = cfg_q.period[CBITS-1:0];

   always_comb begin
      wr_ok      = we && (wr_cfg.period != '0);
      wr_bad     = we && (wr_cfg.period == '0);
      // A write landing on the same edge as an apply point is folded in directly.
      eff_pend   = pend_q || wr_ok;
      eff_cfg    = wr_ok ? wr_cfg : pend_cfg_q;
      tc         = (cnt_q == period - 1'b1);
      err_set    = 1'b0;
      state_d    = state_q;
      cnt_d      = cnt_q;
      cfg_d      = cfg_q;
      pend_cfg_d = pend_cfg_q;
      pend_d     = pend_q;
      sig_d      = 1'b0;

      case (state_q)
         IDLE: begin
            if (wr_ok) cfg_d = wr_cfg;
            if (start && !stop) begin
               state_d = RUN;
               cnt_d   = '0;
            end
         end
         RUN: begin
            if (wr_ok) begin
               pend_d     = 1'b1;
               pend_cfg_d = wr_cfg;
            end
            if (stop) begin
               state_d = IDLE;
               cnt_d   = '0;
               if (eff_pend) cfg_d = eff_cfg;
               pend_d  = 1'b0;
            end else if (start && RETRIG) begin
               cnt_d   = '0;
               if (eff_pend) cfg_d = eff_cfg;
               pend_d  = 1'b0;
            end else if (tc) begin
               sig_d   = 1'b1;
               cnt_d   = '0;
               if (!cfg_q.periodic) state_d = IDLE;
               if (eff_pend) cfg_d = eff_cfg;
               pend_d  = 1'b0;
            end else begin
               cnt_d   = cnt_q + 1'b1;
            end
            if (start && !stop && !RETRIG) err_set = 1'b1;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      flg_d = (state_d == RUN);
      err_d = err_set || wr_bad || (err_q && !err_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         cfg_q      <= RST_CFG;
         pend_cfg_q <= RST_CFG;
         pend_q     <= 1'b0;
         sig_q      <= 1'b0;
         flg_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cfg_q      <= cfg_d;
         pend_cfg_q <= pend_cfg_d;
         pend_q     <= pend_d;
         sig_q      <= sig_d;
         flg_q      <= flg_d;
         err_q      <= err_d;
      end
   end

   assign sig = sig_q;
   assign flg = flg_q;
   assign err = err_q;

   cnt_in_range: assert property (@(posedge clk) disable iff (rst) cnt_q <= period - 1'b1);

endmodule

// File: rtl/delay_timer_bank.sv
// Bank of NCH independent delay/period timers sharing one config write port.
// Macro DELAY_TIMER_RETRIG_EN (in delay_timer_ch) enables restart-on-start while running.
module delay_timer_bank
   import delay_timer_pkg::*;
#(
   parameter int NCH       = 4,
   parameter int CBITS     = CBITS_DEF,
   parameter int DEFAULT_N = DEFAULT_N_DEF
) (
   input logic               clk,
   input logic               rst,
   delay_timer_bank_if.slave bus
);

   cfg_t           wr_cfg;
   logic [NCH-1:0] ch_we;
   logic [NCH-1:0] sig_w;
   logic [NCH-1:0] flg_w;
   logic [NCH-1:0] err_w;

   assign wr_cfg.period   = CBITS_MAX'(bus.cfg_period);
   assign wr_cfg.periodic = bus.cfg_periodic;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      // Out-of-range cfg_ch matches no channel, so the write is silently dropped.
      assign ch_we[g] = bus.cfg_we && (32'(bus.cfg_ch) == g);

      delay_timer_ch #(
         .CBITS     (CBITS),
         .DEFAULT_N (DEFAULT_N)
      ) u_ch (
         .clk     (clk),
         .rst     (rst),
         .we      (ch_we[g]),
         .wr_cfg  (wr_cfg),
         .start   (bus.start[g]),
         .stop    (bus.stop[g]),
         .err_clr (bus.err_clr[g]),
         .sig     (sig_w[g]),
         .flg     (flg_w[g]),
         .err     (err_w[g])
      );
   end

   assign bus.sig = sig_w;
   assign bus.flg = flg_w;
   assign bus.err = err_w;

endmodule

// File: doc/delay_timer_bank.md
Name: delay_timer_bank

Overview:
- Bank of NCH independent programmable delay/period timers.
- Each channel emits a one-cycle `sig` pulse a programmed number of cycles after `start`, in one-shot or periodic mode.
- Each channel also reports `flg` (running) and a sticky `err`.
- Generalises the single fixed-N delay counter into a shared timing resource for protocol timeouts and tick generation.

Parameters:
- NCH, 4: number of channels (1..32).
- CBITS, 16: counter and period width.
- DEFAULT_N, 50000: period loaded at reset; must be 1..2^CBITS-1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  configuration write strobe.
- cfg_ch  in  max(1,$clog2(NCH))  channel addressed by the write.
- cfg_period  in  CBITS  new period P.
- cfg_periodic  in  1  1 = periodic mode, 0 = one-shot.
- start  in  NCH  per-channel start request.
- stop  in  NCH  per-channel stop request.
- err_clr  in  NCH  per-channel clear for `err`.
- sig  out  NCH  one-cycle terminal-count pulse, registered.
- flg  out  NCH  1 while channel is in RUN, registered.
- err  out  NCH  sticky error, registered.

Behaviour:
- Reset (async, rst=1):
  - cnt=0, state=IDLE, period=DEFAULT_N, periodic=0, pending=0.
  - sig=0, flg=0, err=0.
  - Reset overrides everything, including mid-count; no pulse is generated.
- Per-channel states: IDLE and RUN.
- IDLE -> RUN: start[i]=1 and stop[i]=0 at edge k. At that edge cnt<=0, flg<=1.
- Counting in RUN: each edge with cnt != P-1 does cnt<=cnt+1.
- Terminal count: at the edge where cnt==P-1, sig<=1 for exactly one cycle.
  - Periodic: cnt<=0 and stay in RUN.
  - One-shot: go to IDLE, flg<=0.
- Latency: the first sig is high in the cycle after edge k+P, so start-to-pulse is P cycles.
  - Periodic mode: one pulse every P cycles, no gap cycles.
  - P=1: sig held high every cycle in periodic mode.
- Stop: stop[i]=1 in RUN gives IDLE, cnt<=0, flg<=0, no sig.
  - Stop wins over start and over terminal count in the same cycle.
- Config writes (cfg_we with cfg_ch < NCH):
  - cfg_period=0: write ignored, err[cfg_ch]<=1.
  - cfg_ch >= NCH: write ignored, no error.
  - Target IDLE: period and mode update at that edge.
  - Target RUN: values go to a pending shadow and are applied at the next terminal count or stop. The current interval always completes with the old P.
  - A second write while pending: last write wins.
- Start while RUN (without the optional feature): ignored, counting continues, err[i]<=1.
- err is sticky; cleared by err_clr[i]. If set and clear occur in the same cycle, set wins.
- Counter invariant: cnt <= P-1 always. Any other value is a design error; assertion only, no recovery logic.
- Channels are fully independent. Simultaneous events on different channels never interact.
- Arithmetic: unsigned CBITS. The counter never wraps because terminal count precedes 2^CBITS-1.

Optional Feature:
- Macro DELAY_TIMER_RETRIG_EN.
- Defined: start[i] while RUN restarts the interval (cnt<=0), does not set err, and applies any pending config at that edge. Stop still wins over start.
- Not defined: start while RUN is ignored and sets err, as in Behaviour.

Decomposition:
- Package delay_timer_pkg:
  - State enum (IDLE, RUN).
  - Default CBITS and DEFAULT_N constants.
  - Config struct {period, periodic}.
- Sub-module delay_timer_ch: one channel, holding the counter, FSM, shadow config and err.
- Top level: generate loop over NCH instances, decoding cfg_we/cfg_ch into per-channel write enables.

Test Plan:
- Reset defaults (NCH=4): rst pulse, then start[0] with default P=50000 -> sig[0] high exactly one cycle, 50000 cycles after start edge; flg[0] drops with it.
- Periodic P=3 on ch1: cfg write, start -> sig[1] at cycles 3, 6, 9 after start; flg[1] stays 1; stop at cycle 7 -> no pulse at 9, flg[1]=0.
- Mid-run reconfig on ch2: P=10 running, write P=4 at cycle 5 -> pulse at 10, then (periodic) next pulses at 14, 18.
- Errors: write P=0 to ch3 -> err[3]=1 and period unchanged. Start ch0 while running (no macro) -> err[0]=1 and pulse timing unchanged. err_clr together with a new error -> err stays 1.
- Simultaneous events: start+stop same cycle -> stays IDLE. Stop on terminal-count cycle -> no sig. Async rst mid-count at cnt=7 -> all outputs 0 immediately.
- With DELAY_TIMER_RETRIG_EN, P=5: restart at cycle 3 -> pulse at cycle 8, err=0.
